// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES key-schedule constants and the round key sequencer state type.
//   KEY_WIDTH        : width of one round key in bits
//   AES256_NUM_KEYS  : number of round keys in an AES-256 schedule
//   ROUND_IDX_W      : width of the round index carried on round_o
//   state_e          : sequencer states (IDLE, STREAM)
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int KEY_WIDTH       = 128;
   localparam int AES256_NUM_KEYS = 15;
   localparam int ROUND_IDX_W     = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

endpackage : aes_pkg

// File: rtl/round_key_store.sv
// -----------------------------------------------------------------------------
// round_key_store
// Holds one full key schedule, written in a single cycle, and returns the
// entry selected by rd_idx_i combinationally.
//   clk_i      : clock
//   we_i       : write the whole schedule from data_i this cycle
//   data_i     : flat schedule, entry n in bits [n*key_width_p +: key_width_p]
//   rd_idx_i   : entry to read
//   rd_data_o  : selected entry (zero for an index past the last entry)
// The array has no reset: its contents are only observable after a load.
// -----------------------------------------------------------------------------
module round_key_store
   import aes_pkg::*;
#(
   parameter int num_keys_p  = AES256_NUM_KEYS,
   parameter int key_width_p = KEY_WIDTH
) (
   input  logic                                 clk_i,
   input  logic                                 we_i,
   input  logic [0:num_keys_p*key_width_p-1]    data_i,
   input  logic [ROUND_IDX_W-1:0]               rd_idx_i,
   output logic [0:key_width_p-1]               rd_data_o
);

   localparam logic [ROUND_IDX_W-1:0] last_idx_lp = ROUND_IDX_W'(num_keys_p - 1);

   logic [0:key_width_p-1] r_mem [num_keys_p];

   // Capture the complete schedule on a write strobe.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int n = 0; n < num_keys_p; n++) begin
            r_mem[n] <= data_i[n*key_width_p +: key_width_p];
         end
      end
   end

   // Indexed read; the guard keeps an unused index code from reading outside the array.
   always_comb begin
      rd_data_o = {key_width_p{1'b0}};
      if (rd_idx_i <= last_idx_lp) begin
         rd_data_o = r_mem[rd_idx_i];
      end else begin
         rd_data_o = {key_width_p{1'b0}};
      end
   end

endmodule : round_key_store

// File: rtl/round_key_sequencer.sv
// -----------------------------------------------------------------------------
// round_key_sequencer
// Stores an AES round-key schedule and streams it out one key per handshake,
// in forward (encrypt) or reverse (decrypt) order. A stored schedule can be
// replayed with repeat_i without reloading.
//   clk_i         : clock, all state changes on the rising edge
//   reset_i       : synchronous active-high reset
//   round_keys_i  : flat schedule, key n in bits [n*key_width_p +: key_width_p]
//   decrypt_i     : stream order, sampled on acceptance (1 = last key first)
//   v_i           : load round_keys_i and start a stream
//   repeat_i      : start a stream from the stored schedule
//   ready_o       : v_i / repeat_i can be accepted this cycle
//   key_o         : current round key (zero when v_o = 0)
//   round_o       : index of key_o within the schedule (zero when v_o = 0)
//   last_o        : key_o is the final key of this stream (zero when v_o = 0)
//   v_o           : key_o / round_o / last_o valid
//   yumi_i        : consumer takes key_o this cycle
// -----------------------------------------------------------------------------
module round_key_sequencer
   import aes_pkg::*;
#(
   parameter int num_keys_p  = AES256_NUM_KEYS,
   parameter int key_width_p = KEY_WIDTH
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [0:num_keys_p*key_width_p-1] round_keys_i,
   input  logic                              decrypt_i,
   input  logic                              v_i,
   input  logic                              repeat_i,
   output logic                              ready_o,
   output logic [0:key_width_p-1]            key_o,
   output logic [3:0]                        round_o,
   output logic                              last_o,
   output logic                              v_o,
   input  logic                              yumi_i
);

   localparam logic [3:0] last_idx_lp = 4'(num_keys_p - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_index;
   logic [3:0]  w_index_nxt;
   logic        r_loaded;
   logic        w_loaded_nxt;
   logic        r_decrypt;
   logic        w_decrypt_nxt;
   logic        w_we;
   logic        w_last;
   logic [0:key_width_p-1] w_rd_key;

   round_key_store #(
      .num_keys_p  (num_keys_p),
      .key_width_p (key_width_p)
   ) u_store (
      .clk_i     (clk_i),
      .we_i      (w_we),
      .data_i    (round_keys_i),
      .rd_idx_i  (r_index),
      .rd_data_o (w_rd_key)
   );

   // The final key depends on direction: top of the schedule forward, key 0 in reverse.
   assign w_last = r_decrypt ? (r_index == 4'd0) : (r_index == last_idx_lp);

   // State, index, loaded flag and direction registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_index   <= 4'd0;
         r_loaded  <= 1'b0;
         r_decrypt <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_index   <= w_index_nxt;
         r_loaded  <= w_loaded_nxt;
         r_decrypt <= w_decrypt_nxt;
      end
   end

   // Next-state logic: accept a load or replay in IDLE, step the index per handshake in STREAM.
   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_index;
      w_loaded_nxt  = r_loaded;
      w_decrypt_nxt = r_decrypt;
      w_we          = 1'b0;
      case (r_state)
         IDLE: begin
            // A fresh load takes priority over a replay request in the same cycle.
            if (v_i) begin
               w_we          = 1'b1;
               w_loaded_nxt  = 1'b1;
               w_decrypt_nxt = decrypt_i;
               w_index_nxt   = decrypt_i ? last_idx_lp : 4'd0;
               w_state_nxt   = STREAM;
            end else if (repeat_i && r_loaded) begin
               w_decrypt_nxt = decrypt_i;
               w_index_nxt   = decrypt_i ? last_idx_lp : 4'd0;
               w_state_nxt   = STREAM;
            end else begin
               w_state_nxt   = IDLE;
            end
         end
         STREAM: begin
            // Index stops on the final key rather than wrapping.
            if (yumi_i) begin
               if (w_last) begin
                  w_state_nxt = IDLE;
               end else if (r_decrypt) begin
                  w_index_nxt = r_index - 4'd1;
               end else begin
                  w_index_nxt = r_index + 4'd1;
               end
            end else begin
               w_state_nxt = STREAM;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output stage: handshake flags from state, data forced to zero outside STREAM.
   always_comb begin
      ready_o = 1'b0;
      v_o     = 1'b0;
      key_o   = {key_width_p{1'b0}};
      round_o = 4'd0;
      last_o  = 1'b0;
      if (r_state == STREAM) begin
         v_o     = 1'b1;
         key_o   = w_rd_key;
         round_o = r_index;
         last_o  = w_last;
      end else begin
         ready_o = 1'b1;
      end
   end

endmodule : round_key_sequencer

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

   localparam int NK = 15;
   localparam int KW = 128;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [0:NK*KW-1]  round_keys_i;
   logic              decrypt_i;
   logic              v_i;
   logic              repeat_i;
   logic              ready_o;
   logic [0:KW-1]     key_o;
   logic [3:0]        round_o;
   logic              last_o;
   logic              v_o;
   logic              yumi_i;

   always #5 clk_i = ~clk_i;

   round_key_sequencer #(.num_keys_p(NK), .key_width_p(KW)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .round_keys_i (round_keys_i),
      .decrypt_i    (decrypt_i),
      .v_i          (v_i),
      .repeat_i     (repeat_i),
      .ready_o      (ready_o),
      .key_o        (key_o),
      .round_o      (round_o),
      .last_o       (last_o),
      .v_o          (v_o),
      .yumi_i       (yumi_i)
   );

   typedef struct packed {
      logic [3:0]    rnd;
      logic [0:KW-1] key;
      logic          last;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad   = 0;
   logic [7:0] model_b [NK];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [0:NK*KW-1] make_sched(input logic [7:0] base);
      logic [0:NK*KW-1] s;
      for (int n = 0; n < NK; n++) s[n*KW +: KW] = {16{base + 8'(n)}};
      return s;
   endfunction

   task automatic set_model(input logic [7:0] base);
      for (int n = 0; n < NK; n++) model_b[n] = base + 8'(n);
   endtask

   // Queue the expected keys of one complete stream from the reference schedule.
   task automatic push_stream(input logic dec);
      exp_t e;
      int   idx;
      for (int i = 0; i < NK; i++) begin
         idx    = dec ? (NK - 1 - i) : i;
         e.rnd  = 4'(idx);
         e.key  = {16{model_b[idx]}};
         e.last = (i == NK - 1);
         sb_q.push_back(e);
      end
   endtask

   // Monitor: compares every handshake against the scoreboard and checks hold during stalls.
   logic [0:KW-1] prev_key;
   logic [3:0]    prev_rnd;
   logic          prev_last;
   logic          prev_stall = 1'b0;
   exp_t          got_e;

   always @(negedge clk_i) begin
      if (prev_stall && v_o) begin
         check("hold_key",   key_o,   prev_key);
         check("hold_round", round_o, prev_rnd);
         check("hold_last",  last_o,  prev_last);
      end
      if (v_o && yumi_i) begin
         if (sb_q.size() == 0) begin
            check("unexpected_key", 1'b1, 1'b0);
         end else begin
            got_e = sb_q.pop_front();
            check("key_o",   key_o,   got_e.key);
            check("round_o", round_o, got_e.rnd);
            check("last_o",  last_o,  got_e.last);
         end
      end
      prev_stall <= v_o && !yumi_i;
      prev_key   <= key_o;
      prev_rnd   <= round_o;
      prev_last  <= last_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Consume a stream; rnd_mode throttles yumi_i at random, otherwise it is held high.
   task automatic run_stream(input bit rnd_mode, output int hs);
      int guard;
      hs    = 0;
      guard = 0;
      while (v_o && guard < 200) begin
         yumi_i = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (yumi_i) hs++;
         tick();
         guard++;
      end
      yumi_i = 1'b0;
      check("stream_end_v_o", v_o, 1'b0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, ready_o, 1'b1);
      check({tag, "_v_o"},   v_o,     1'b0);
      check({tag, "_key"},   key_o,   128'd0);
      check({tag, "_round"}, round_o, 4'd0);
      check({tag, "_last"},  last_o,  1'b0);
   endtask

   int hs;
   int g;

   initial begin
      reset_i      = 1'b1;
      round_keys_i = '0;
      decrypt_i    = 1'b0;
      v_i          = 1'b0;
      repeat_i     = 1'b0;
      yumi_i       = 1'b0;
      tick();
      check_idle("reset");
      tick();
      reset_i = 1'b0;

      // Forward stream, yumi held high: 15 consecutive keys.
      set_model(8'h00);
      round_keys_i = make_sched(8'h00);
      decrypt_i    = 1'b0;
      v_i          = 1'b1;
      push_stream(1'b0);
      tick();
      v_i = 1'b0;
      check("enc_first_v_o",   v_o,     1'b1);
      check("enc_first_round", round_o, 4'd0);
      check("enc_first_ready", ready_o, 1'b0);
      run_stream(1'b0, hs);
      check("enc_cycles", 32'(hs), 32'd15);
      check("enc_after_ready", ready_o, 1'b1);

      // Reverse stream with random stalls.
      decrypt_i = 1'b1;
      v_i       = 1'b1;
      push_stream(1'b1);
      tick();
      v_i = 1'b0;
      check("dec_first_round", round_o, 4'd14);
      check("dec_first_last",  last_o,  1'b0);
      run_stream(1'b1, hs);
      check("dec_handshakes", 32'(hs), 32'd15);
      check("dec_after_ready", ready_o, 1'b1);

      // Replay ignores the changed input schedule, then a load replaces storage.
      round_keys_i = '1;
      decrypt_i    = 1'b0;
      repeat_i     = 1'b1;
      push_stream(1'b0);
      tick();
      repeat_i = 1'b0;
      check("rep_v_o", v_o, 1'b1);
      run_stream(1'b1, hs);
      set_model(8'h20);
      round_keys_i = make_sched(8'h20);
      v_i          = 1'b1;
      push_stream(1'b0);
      tick();
      v_i = 1'b0;
      run_stream(1'b0, hs);

      // Replay with nothing loaded is ignored; load wins over a coincident replay.
      reset_i = 1'b1;
      tick();
      reset_i  = 1'b0;
      repeat_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("noload_ready", ready_o, 1'b1);
         check("noload_v_o",   v_o,     1'b0);
      end
      set_model(8'h40);
      round_keys_i = make_sched(8'h40);
      decrypt_i    = 1'b1;
      v_i          = 1'b1;
      push_stream(1'b1);
      tick();
      v_i      = 1'b0;
      repeat_i = 1'b0;
      check("both_v_o",   v_o,     1'b1);
      check("both_round", round_o, 4'd14);
      run_stream(1'b0, hs);

      // Reset at round 7 aborts the stream and clears the loaded flag.
      set_model(8'h00);
      round_keys_i = make_sched(8'h00);
      decrypt_i    = 1'b0;
      v_i          = 1'b1;
      push_stream(1'b0);
      tick();
      v_i = 1'b0;
      g   = 0;
      while (round_o != 4'd7 && g < 50) begin
         yumi_i = 1'b1;
         tick();
         g++;
      end
      yumi_i = 1'b0;
      check("abort_at_round", round_o, 4'd7);
      reset_i = 1'b1;
      sb_q.delete();
      tick();
      reset_i = 1'b0;
      check_idle("abort");
      repeat_i = 1'b1;
      tick();
      tick();
      check("abort_rep_v_o",   v_o,     1'b0);
      check("abort_rep_ready", ready_o, 1'b1);
      repeat_i = 1'b0;

      // v_i held through the stream is only taken after one idle cycle.
      set_model(8'h10);
      round_keys_i = make_sched(8'h10);
      decrypt_i    = 1'b0;
      v_i          = 1'b1;
      push_stream(1'b0);
      tick();
      set_model(8'h60);
      round_keys_i = make_sched(8'h60);
      push_stream(1'b0);
      run_stream(1'b0, hs);
      check("gap_cycles", 32'(hs), 32'd15);
      check("gap_ready",  ready_o, 1'b1);
      tick();
      v_i = 1'b0;
      check("second_v_o",   v_o,     1'b1);
      check("second_round", round_o, 4'd0);
      run_stream(1'b0, hs);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_round_key_sequencer

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 The block SHALL provide parameter num_keys_p, default 15, number of 128-bit round keys held (AES-256).
REQ-002 The block SHALL provide parameter key_width_p, default 128, width of one round key.
REQ-003 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_i, input, 1: synchronous, active-high reset.
REQ-005 Port round_keys_i, input, [0:num_keys_p*key_width_p-1]: flat key schedule; key 0 in bits [0:127], key n in bits [128n:128n+127].
REQ-006 Port decrypt_i, input, 1: stream order, sampled on acceptance; 0 = key 0 first, 1 = key num_keys_p-1 first.
REQ-007 Port v_i, input, 1: round_keys_i and decrypt_i valid.
REQ-008 Port repeat_i, input, 1: request a new stream from already-stored keys, with decrypt_i.
REQ-009 Port ready_o, output, 1: block can accept v_i or repeat_i this cycle.
REQ-010 Port key_o, output, [0:key_width_p-1]: current round key.
REQ-011 Port round_o, output, 4: index of key_o within the schedule (0..num_keys_p-1).
REQ-012 Port last_o, output, 1: key_o is the final key of the current stream.
REQ-013 Port v_o, output, 1: key_o/round_o/last_o valid.
REQ-014 Port yumi_i, input, 1: consumer takes key_o this cycle; legal only while v_o=1.

Function
REQ-015 Two states SHALL exist: IDLE (ready_o=1, v_o=0) and STREAM (ready_o=0, v_o=1).
REQ-016 Load: v_i & ready_o SHALL copy round_keys_i into internal storage, set a loaded flag, latch decrypt_i, and enter STREAM.
REQ-017 Repeat: repeat_i & ready_o & loaded & ~v_i SHALL latch decrypt_i and enter STREAM without changing storage.
REQ-018 repeat_i with loaded=0 SHALL be ignored; v_i SHALL win when v_i and repeat_i coincide.
REQ-019 On entry to STREAM the index SHALL be 0 (decrypt=0) or num_keys_p-1 (decrypt=1); v_o asserts the cycle after acceptance (latency 1).
REQ-020 key_o SHALL equal storage[index], round_o SHALL equal index, while v_o=1.
REQ-021 key_o, round_o, last_o SHALL be all-zero while v_o=0.
REQ-022 key_o/round_o/last_o SHALL hold stable while v_o=1 and yumi_i=0.
REQ-023 yumi_i in STREAM SHALL step index by +1 (encrypt) or -1 (decrypt) next cycle.
REQ-024 last_o SHALL be 1 exactly when index = num_keys_p-1 (encrypt) or 0 (decrypt).
REQ-025 yumi_i while last_o=1 SHALL return to IDLE next cycle; index never wraps.
REQ-026 yumi_i while v_o=0 SHALL be ignored.
REQ-027 v_i or repeat_i during STREAM SHALL be ignored (ready_o=0); no same-cycle reload on the final yumi, giving one idle cycle between streams.
REQ-028 Storage SHALL change only on an accepted v_i.

Reset
REQ-029 reset_i SHALL force IDLE, index 0, loaded 0, latched decrypt 0; next cycle ready_o=1, v_o=0, key_o=0, round_o=0, last_o=0.
REQ-030 reset_i mid-stream SHALL abort the stream; subsequent repeat_i is ignored until a new v_i load.
REQ-031 Key storage contents SHALL not require reset.

Structure
REQ-032 Shared package aes_pkg SHALL hold key width 128, AES-256 round-key count 15, and the state enum (IDLE, STREAM).
REQ-033 Storage and read mux SHALL be sub-module round_key_store (write-enable array of num_keys_p entries, combinational indexed read); FSM and index counter stay in round_key_sequencer.

Verification (key n = 16 bytes each equal to n, e.g. key 3 = 0303...03)
REQ-034 Reset, load with decrypt=0, yumi_i held 1 -> 15 consecutive cycles round_o 0..14, key_o 00..00 ... 0e..0e, last_o only at round 14, then ready_o=1.
REQ-035 Load decrypt=1, yumi_i random 50% -> round_o 14 down to 0 with no skips or repeats, keys held across stall cycles, last_o at round 0.
REQ-036 After stream, repeat_i with decrypt=0 and round_keys_i changed to all-FF -> original keys 00..0e streamed; then v_i load replaces them.
REQ-037 repeat_i after reset with no load -> ready_o stays 1, v_o stays 0; v_i+repeat_i together -> new keys loaded and streamed.
REQ-038 reset_i at round 7 -> next cycle v_o=0, ready_o=1, outputs zero; repeat_i ignored.
REQ-039 v_i asserted throughout STREAM and on final yumi -> not accepted until IDLE; one-cycle gap, then new stream from round 0.
